// File: rtl/ibex_data_mem_ctrl_if.sv
// Data-side request/response bus between the LSU and the data memory
// controller: req/gnt handshake carrying address, write enable, byte enables
// and write data, plus an in-order rvalid response carrying rdata and err.
interface ibex_data_mem_ctrl_if;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_err_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;

    // LSU side: issues requests, consumes grants and responses.
    modport master (
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o
    );

    // Memory side: grants requests and returns responses.
    modport slave (
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o
    );
endinterface

// File: rtl/ibex_data_mem_ctrl.sv
// Tightly coupled data memory controller. Accepts word-aligned LSU requests,
// writes/reads an internal word array at the grant edge and returns in-order
// responses after exactly RESP_LATENCY cycles. Accesses outside the mapped
// window leave the array untouched and complete with err=1, rdata=0.
module ibex_data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0010_0000,
    parameter int unsigned RESP_LATENCY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    ibex_data_mem_ctrl_if.slave        bus,
    input  logic                       stall_i,
    output logic [2:0]                 outstanding_o,
    output logic                       busy_o
);
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    // One past the last mapped byte; 33 bits so a window ending at 4 GiB works.
    localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0]             mem [DEPTH_WORDS];
    logic                    in_range;
    logic [31:0]             byte_off;
    logic [IDX_W-1:0]        word_idx;
    logic                    gnt;
    logic                    rvalid;

    // Response pipeline: valid is reset, payload is not (it is gated by valid).
    logic [RESP_LATENCY-1:0] vld_p;
    logic                    err_p   [RESP_LATENCY];
    logic [31:0]             rdata_p [RESP_LATENCY];

    assign in_range = ({1'b0, bus.data_addr_i} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, bus.data_addr_i} <  ADDR_LIMIT);
    assign byte_off = bus.data_addr_i - BASE_ADDR;
    assign word_idx = IDX_W'(byte_off >> 2);

    // A response leaving this cycle frees its slot for a new grant right away.
    assign rvalid = vld_p[RESP_LATENCY-1];
    assign gnt    = bus.data_req_i & ~stall_i &
                    ((outstanding_o < 3'(MAX_OUTSTANDING)) | rvalid);

    assign bus.data_gnt_o    = gnt;
    assign bus.data_rvalid_o = rvalid;
    assign bus.data_err_o    = rvalid & err_p[RESP_LATENCY-1];
    assign bus.data_rdata_o  = rvalid ? rdata_p[RESP_LATENCY-1] : 32'h0;
    assign busy_o            = (outstanding_o != 3'd0);

    // Byte-lane write into the array at the grant edge of an in-range write.
    always_ff @(posedge clk_i) begin
        if (gnt && in_range && bus.data_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_be_i[b]) begin
                    mem[word_idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 captures the response payload at the grant edge; later stages shift.
    always_ff @(posedge clk_i) begin
        err_p[0]   <= ~in_range;
        rdata_p[0] <= (in_range && !bus.data_we_i) ? mem[word_idx] : 32'h0;
        for (int i = 1; i < RESP_LATENCY; i++) begin
            err_p[i]   <= err_p[i-1];
            rdata_p[i] <= rdata_p[i-1];
        end
    end

    // Valid pipeline: a grant enters stage 0 and pops out RESP_LATENCY cycles later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= gnt;
            for (int i = 1; i < RESP_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Outstanding counter: +1 per grant, -1 per response, net zero when both.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_o <= 3'd0;
        end else begin
            case ({gnt, rvalid})
                2'b10:   outstanding_o <= outstanding_o + 3'd1;
                2'b01:   outstanding_o <= outstanding_o - 3'd1;
                default: outstanding_o <= outstanding_o;
            endcase
        end
    end
endmodule

// File: tb/tb_ibex_data_mem_ctrl.sv
// Bench for ibex_data_mem_ctrl: two instances (latency 1 / cap 1 and
// latency 3 / cap 2) share one stimulus stream; each is compared every cycle
// against a transaction-level model (word array + FIFO of timed responses).
module tb_ibex_data_mem_ctrl;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0010_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall;
    always #5 clk = ~clk;

    ibex_data_mem_ctrl_if bus_a ();
    ibex_data_mem_ctrl_if bus_b ();
    logic [2:0] out_a, out_b;
    logic       busy_a, busy_b;

    ibex_data_mem_ctrl #(
        .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RESP_LATENCY(1), .MAX_OUTSTANDING(1)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_a), .stall_i(stall),
        .outstanding_o(out_a), .busy_o(busy_a)
    );

    ibex_data_mem_ctrl #(
        .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RESP_LATENCY(3), .MAX_OUTSTANDING(2)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_b), .stall_i(stall),
        .outstanding_o(out_b), .busy_o(busy_b)
    );

    // Observed outputs, indexed by instance.
    logic        obs_gnt [2];
    logic        obs_rv  [2];
    logic        obs_err [2];
    logic [31:0] obs_rd  [2];
    logic [2:0]  obs_out [2];
    logic        obs_busy[2];
    assign obs_gnt[0] = bus_a.data_gnt_o;    assign obs_gnt[1] = bus_b.data_gnt_o;
    assign obs_rv[0]  = bus_a.data_rvalid_o; assign obs_rv[1]  = bus_b.data_rvalid_o;
    assign obs_err[0] = bus_a.data_err_o;    assign obs_err[1] = bus_b.data_err_o;
    assign obs_rd[0]  = bus_a.data_rdata_o;  assign obs_rd[1]  = bus_b.data_rdata_o;
    assign obs_out[0] = out_a;               assign obs_out[1] = out_b;
    assign obs_busy[0] = busy_a;             assign obs_busy[1] = busy_b;

    // Reference model state per instance.
    logic [31:0] mdl_mem   [2][DEPTH];
    logic [3:0]  mdl_known [2][DEPTH];
    int          q_due     [2][16];
    logic        q_err     [2][16];
    logic [31:0] q_data    [2][16];
    logic        q_chk     [2][16];
    int          q_head    [2];
    int          q_cnt     [2];
    logic        last_gnt  [2];

    int cyc    = 0;
    int n_vec  = 0;
    int n_err  = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int max_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Compare one instance for the current cycle, then advance its model.
    task automatic model_cycle(input int k, input logic req, input logic we,
                               input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata, input logic stl);
        bit          exp_rv, exp_g, inr;
        int          h, t, idx;
        longint      a;
        logic [31:0] rd;
        exp_rv = (q_cnt[k] > 0) && (q_due[k][q_head[k]] == cyc);
        exp_g  = req && !stl && ((q_cnt[k] < max_of(k)) || exp_rv);
        chk($sformatf("outstanding%0d", k), 32'(obs_out[k]), 32'(q_cnt[k]));
        chk($sformatf("busy%0d", k), 32'(obs_busy[k]), 32'(q_cnt[k] != 0));
        chk($sformatf("gnt%0d", k), 32'(obs_gnt[k]), 32'(exp_g));
        chk($sformatf("rvalid%0d", k), 32'(obs_rv[k]), 32'(exp_rv));
        if (exp_rv) begin
            h = q_head[k];
            chk($sformatf("err%0d", k), 32'(obs_err[k]), 32'(q_err[k][h]));
            if (q_chk[k][h]) chk($sformatf("rdata%0d", k), obs_rd[k], q_data[k][h]);
            q_head[k] = (h + 1) % 16;
            q_cnt[k]--;
        end else begin
            chk($sformatf("idle_err%0d", k), 32'(obs_err[k]), 32'd0);
            chk($sformatf("idle_rdata%0d", k), obs_rd[k], 32'd0);
        end
        last_gnt[k] = exp_g;
        if (exp_g) begin
            a   = longint'(addr);
            inr = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
            idx = inr ? int'((addr - BASE) >> 2) : 0;
            rd  = 32'h0;
            t   = (q_head[k] + q_cnt[k]) % 16;
            q_chk[k][t] = 1'b1;
            if (inr && !we) begin
                rd = mdl_mem[k][idx];
                q_chk[k][t] = (mdl_known[k][idx] == 4'hF);
            end
            if (inr && we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mdl_mem[k][idx][8*b +: 8] = wdata[8*b +: 8];
                        mdl_known[k][idx][b] = 1'b1;
                    end
                end
            end
            q_due[k][t]  = cyc + lat_of(k);
            q_err[k][t]  = !inr;
            q_data[k][t] = rd;
            q_cnt[k]++;
        end
    endtask

    task automatic step(input logic req, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata, input logic stl);
        @(negedge clk);
        cyc++;
        bus_a.data_req_i = req;   bus_b.data_req_i = req;
        bus_a.data_we_i = we;     bus_b.data_we_i = we;
        bus_a.data_addr_i = addr; bus_b.data_addr_i = addr;
        bus_a.data_be_i = be;     bus_b.data_be_i = be;
        bus_a.data_wdata_i = wdata; bus_b.data_wdata_i = wdata;
        stall = stl;
        #1;
        for (int k = 0; k < 2; k++) model_cycle(k, req, we, addr, be, wdata, stl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    endtask

    // Single access followed by enough idle time for both instances to drain.
    task automatic op(input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata);
        step(1'b1, we, addr, be, wdata, 1'b0);
        idle(3);
    endtask

    task automatic check_quiet(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_rvalid%0d", tag, k), 32'(obs_rv[k]), 32'd0);
            chk($sformatf("%s_err%0d", tag, k), 32'(obs_err[k]), 32'd0);
            chk($sformatf("%s_rdata%0d", tag, k), obs_rd[k], 32'd0);
            chk($sformatf("%s_out%0d", tag, k), 32'(obs_out[k]), 32'd0);
            chk($sformatf("%s_busy%0d", tag, k), 32'(obs_busy[k]), 32'd0);
            chk($sformatf("%s_gnt%0d", tag, k), 32'(obs_gnt[k]), 32'd0);
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        cyc++;
        bus_a.data_req_i = 1'b0; bus_b.data_req_i = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_quiet("rst_assert");
        for (int k = 0; k < 2; k++) begin
            q_cnt[k]  = 0;
            q_head[k] = 0;
        end
        @(negedge clk); cyc++;
        @(negedge clk); cyc++;
        rst_n = 1'b1;
        #1;
        check_quiet("rst_release");
    endtask

    initial begin
        logic [31:0] addr;
        int          i;
        for (int k = 0; k < 2; k++) begin
            q_cnt[k] = 0; q_head[k] = 0; last_gnt[k] = 1'b0;
            for (int w = 0; w < DEPTH; w++) begin
                mdl_mem[k][w] = 32'h0; mdl_known[k][w] = 4'h0;
            end
        end
        bus_a.data_req_i = 1'b0; bus_b.data_req_i = 1'b0;
        bus_a.data_we_i = 1'b0;  bus_b.data_we_i = 1'b0;
        bus_a.data_addr_i = 32'h0; bus_b.data_addr_i = 32'h0;
        bus_a.data_be_i = 4'h0;  bus_b.data_be_i = 4'h0;
        bus_a.data_wdata_i = 32'h0; bus_b.data_wdata_i = 32'h0;
        stall = 1'b0;
        #2;
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the array so every later read has a defined expectation.
        for (int w = 0; w < DEPTH; w++) op(1'b1, BASE + 32'(4 * w), 4'hF, $urandom);

        // Write then read back, back to back.
        step(1'b1, 1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        step(1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0, 1'b0);
        idle(4);

        // Partial write of one lane over a known word.
        op(1'b1, BASE + 32'h20, 4'hF, 32'h11223344);
        op(1'b1, BASE + 32'h20, 4'b0100, 32'h00AA0000);
        op(1'b0, BASE + 32'h20, 4'h0, 32'h0);
        op(1'b1, BASE + 32'h24, 4'h0, 32'hFFFFFFFF);
        op(1'b0, BASE + 32'h24, 4'h0, 32'h0);

        // Window edges and out-of-range accesses.
        op(1'b0, BASE + 32'(4 * DEPTH), 4'h0, 32'h0);
        op(1'b0, BASE - 32'd4, 4'h0, 32'h0);
        op(1'b1, BASE + 32'(4 * DEPTH), 4'hF, 32'hBAADF00D);
        op(1'b1, BASE - 32'd4, 4'hF, 32'hBAADF00D);
        op(1'b0, BASE, 4'h0, 32'h0);
        op(1'b0, BASE + 32'(4 * (DEPTH - 1)) + 32'd3, 4'h0, 32'h0);

        // Req held high: six reads paced by the latency-3 instance's grants.
        i = 0;
        for (int c = 0; c < 50 && i < 6; c++) begin
            step(1'b1, 1'b0, BASE + 32'(4 * i), 4'h0, 32'h0, 1'b0);
            if (last_gnt[1]) i++;
        end
        chk("burst_reads_done", 32'(i), 32'd6);
        idle(4);

        // Backpressure with req held high, then release.
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0, BASE + 32'h8, 4'h0, 32'h0, 1'b1);
        step(1'b1, 1'b0, BASE + 32'h8, 4'h0, 32'h0, 1'b0);
        idle(4);

        // Reset with responses in flight; earlier writes must survive.
        step(1'b1, 1'b1, BASE + 32'h30, 4'hF, 32'hCAFEF00D, 1'b0);
        step(1'b1, 1'b0, BASE + 32'h4, 4'h0, 32'h0, 1'b0);
        mid_reset();
        op(1'b0, BASE + 32'h30, 4'h0, 32'h0);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 9))
                0:       addr = BASE - 32'(4 * $urandom_range(1, 3));
                1:       addr = BASE + 32'(4 * (DEPTH + $urandom_range(0, 2)));
                2:       addr = $urandom;
                default: addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            endcase
            addr[1:0] = 2'($urandom_range(0, 3));
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, addr,
                 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 4) == 0);
        end
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ibex_data_mem_ctrl.md
Name: ibex_data_mem_ctrl

Overview:
Data-side memory controller directly downstream of the core's load/store unit. It consumes word-aligned req/gnt/rvalid transactions (addr, we, be, wdata) and returns in-order responses (rdata, err) after a fixed latency. Backing store is an on-block word-addressed SRAM array with byte-enable writes. Out-of-range accesses complete with an error response. Used as the core's tightly coupled data memory and as the LSU verification target.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of 2, >=4)
BASE_ADDR, 32'h0010_0000, byte address of word 0 (DEPTH_WORDS*4 aligned)
RESP_LATENCY, 1, cycles from grant to rvalid (legal 1..4)
MAX_OUTSTANDING, 1, cap on granted-but-unanswered requests (legal 1..RESP_LATENCY)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
data_req_i  in  1  request valid from LSU
data_gnt_o  out  1  request accepted this cycle
data_rvalid_o  out  1  response valid
data_err_o  out  1  response is a bus error (qualified by rvalid)
data_addr_i  in  32  byte address; bits [1:0] ignored
data_we_i  in  1  1 = write, 0 = read
data_be_i  in  4  byte enables, bit n = byte lane n
data_wdata_i  in  32  write data, lane-aligned
data_rdata_o  out  32  read data (qualified by rvalid)
stall_i  in  1  backpressure injection; 1 suppresses gnt
outstanding_o  out  3  count of granted requests awaiting response
busy_o  out  1  outstanding_o != 0

Behaviour:
- Clock clk_i; reset rst_ni, asynchronous, active-low.
- Reset: data_gnt_o=0 (combinational, req low), data_rvalid_o=0, data_err_o=0, data_rdata_o=0, outstanding_o=0, busy_o=0. Array contents not reset (undefined until written).
- Grant (combinational): data_gnt_o = data_req_i & ~stall_i & (outstanding_o < MAX_OUTSTANDING | data_rvalid_o). Slot freed by a response is reusable same cycle. At most one grant per cycle.
- In-range: BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS; index = (addr - BASE_ADDR) >> 2.
- Granted in-range write: lanes with be set updated at the grant clock edge; others unchanged. be=0 is legal no-op write.
- Granted in-range read: word read at the grant edge into response pipeline stage 0.
- Out-of-range (read or write): array untouched; response err=1, rdata=0.
- Response pipeline: RESP_LATENCY stages of {valid, err, rdata}; advances every cycle, no stall. Grant in cycle T -> data_rvalid_o high in exactly T+RESP_LATENCY, for one cycle. Responses strictly in grant order.
- Write responses: rvalid with err per range check, rdata=0.
- data_rdata_o and data_err_o forced to 0 whenever data_rvalid_o=0.
- Ordering hazard: write granted in T, read of same word granted in T+1 returns new data (write precedes read; no bypass needed since array updates at grant edge).
- outstanding_o: +1 on grant, -1 on rvalid, unchanged if both in same cycle; never exceeds MAX_OUTSTANDING.
- stall_i only affects new grants; in-flight responses still return on schedule.
- Request with req high and no gnt: no state change; controller holds no copy of request fields.
- Reset mid-operation: pipeline and counter cleared asynchronously; pending responses dropped; writes already granted remain in array.

Test Plan:
- Write addr=BASE_ADDR+0x10, be=4'b1111, wdata=32'hDEADBEEF; then read same addr, LATENCY=1 -> gnt same cycle as req, read rvalid 1 cycle after grant with rdata=32'hDEADBEEF, err=0.
- Partial write be=4'b0100 wdata=32'h00AA0000 over 32'h11223344 -> subsequent read returns 32'h11AA3344.
- Read addr=BASE_ADDR+4*DEPTH_WORDS and addr=BASE_ADDR-4 -> rvalid with err=1, rdata=0; prior write to out-of-range addr leaves word 0 unchanged.
- RESP_LATENCY=3, MAX_OUTSTANDING=2, req held high for 6 reads -> gnt in cycles 0,1, then stalls until first rvalid in cycle 3 (gnt re-asserts same cycle); outstanding_o never exceeds 2; rdata in grant order.
- stall_i=1 for 4 cycles with req high -> gnt=0 throughout, outstanding_o unchanged; gnt in first cycle stall_i drops.
- Reset asserted with 2 responses in flight (LATENCY=3) -> rvalid, outstanding_o, busy_o all 0 immediately and stay 0 after release; earlier-granted write data readable afterwards.
